// File: rtl/alu_op_sequencer.sv
// Command FIFO plus IDLE/DRIVE/RESP sequencer in front of a combinational 4-bit ALU.
// Optional result self-check (chk_err, err_count) when ALU_SEQ_CHECK_EN is defined.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_a,
  input  logic [3:0]                    cmd_b,
  input  logic [1:0]                    cmd_op,
  output logic [3:0]                    alu_a,
  output logic [3:0]                    alu_b,
  output logic [1:0]                    alu_op,
  input  logic [7:0]                    alu_result,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [7:0]                    res_data,
  output logic [1:0]                    res_op,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef ALU_SEQ_CHECK_EN
  ,
  output logic                          chk_err,
  output logic [7:0]                    err_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t        r_state, w_next;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_settle;
  logic [3:0]    r_alu_a, r_alu_b;
  logic [1:0]    r_alu_op, r_res_op;
  logic [7:0]    r_res_data;
  logic          r_res_valid;
  logic          w_push, w_pop, w_capture, w_ack;
  logic [9:0]    w_head;

  assign cmd_ready  = (r_count < CW'(FIFO_DEPTH));
  assign w_push     = cmd_valid && cmd_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_op     = r_res_op;
  assign fifo_count = r_count;
  assign busy       = (r_state != IDLE) || (r_count != '0);

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_ack     = 1'b0;
    case (r_state)
      IDLE: if (r_count != '0) begin
        w_pop  = 1'b1;
        w_next = DRIVE;
      end
      DRIVE: if (r_settle == '0) begin
        w_capture = 1'b1;
        w_next    = RESP;
      end
      RESP: if (res_ready) begin
        w_ack  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op};
  end

  // Count sees the old pop decision, so a full FIFO cannot accept on the pop edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_settle    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_res_data  <= '0;
      r_res_op    <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        {r_alu_a, r_alu_b, r_alu_op} <= w_head;
        r_settle <= SW'(SETTLE - 1);
      end else if (r_state == DRIVE && r_settle != '0) begin
        r_settle <= r_settle - 1'b1;
      end
      if (w_capture) begin
        r_res_data  <= alu_result;
        r_res_op    <= r_alu_op;
        r_res_valid <= 1'b1;
      end else if (w_ack) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [7:0] w_ref;

  always_comb begin
    w_ref = '0;
    case (r_alu_op)
      2'd0: w_ref = {4'h0, r_alu_a} + {4'h0, r_alu_b};
      2'd1: w_ref = {4'h0, r_alu_a} - {4'h0, r_alu_b};
      2'd2: w_ref = {4'h0, r_alu_a & r_alu_b};
      2'd3: w_ref = {4'h0, r_alu_a | r_alu_b};
      default: w_ref = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err   <= 1'b0;
      err_count <= '0;
    end else if (w_capture && (alu_result != w_ref)) begin
      chk_err <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized + directed bench for alu_op_sequencer against a queue-based transaction model.
module tb_alu_op_sequencer;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic [1:0] res_op;
  logic       busy;
  logic [2:0] fifo_count;
  logic       force_zero = 1'b0;
`ifdef ALU_SEQ_CHECK_EN
  logic       chk_err;
  logic [7:0] err_count;
`endif

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  alu_op_sequencer #(.FIFO_DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .busy(busy), .fifo_count(fifo_count)
`ifdef ALU_SEQ_CHECK_EN
    , .chk_err(chk_err), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(cmd_t c);
    case (c.op)
      2'd0:    return {4'h0, c.a} + {4'h0, c.b};
      2'd1:    return {4'h0, c.a} - {4'h0, c.b};
      2'd2:    return {4'h0, c.a & c.b};
      default: return {4'h0, c.a | c.b};
    endcase
  endfunction

  assign alu_result = force_zero ? 8'h00 : alu_fn(cmd_t'({alu_a, alu_b, alu_op}));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: pending queue, one in-flight command with a cycle timer, held result.
  cmd_t       mq[$];
  cmd_t       mcur;
  bit         m_fly, m_rv;
  int         m_left, m_err;
  logic [7:0] m_rd;
  logic [1:0] m_ro;
  logic [9:0] got[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcur = '0; m_fly = 0; m_rv = 0; m_left = 0; m_err = 0; m_rd = '0; m_ro = '0;
    end else begin
      bit push;
      push = cmd_valid && (mq.size() < DEPTH);
      if (res_valid && res_ready) got.push_back({res_op, res_data});
      if (m_rv) begin
        if (res_ready) begin m_rv = 0; m_fly = 0; end
      end else if (m_fly) begin
        m_left--;
        if (m_left == 0) begin
          m_rd = force_zero ? 8'h00 : alu_fn(mcur);
          m_ro = mcur.op;
          m_rv = 1;
          if (m_rd != alu_fn(mcur) && m_err < 255) m_err++;
        end
      end else if (mq.size() > 0) begin
        mcur = mq.pop_front();
        m_fly = 1;
        m_left = SETTLE;
      end
      if (push) mq.push_back(cmd_t'({cmd_a, cmd_b, cmd_op}));
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmd_ready", int'(cmd_ready), int'(mq.size() < DEPTH));
      chk("fifo_count", int'(fifo_count), mq.size());
      chk("busy", int'(busy), int'(m_fly || mq.size() > 0));
      chk("res_valid", int'(res_valid), int'(m_rv));
      chk("res_data", int'(res_data), int'(m_rd));
      chk("res_op", int'(res_op), int'(m_ro));
      chk("alu_a", int'(alu_a), int'(mcur.a));
      chk("alu_b", int'(alu_b), int'(mcur.b));
      chk("alu_op", int'(alu_op), int'(mcur.op));
`ifdef ALU_SEQ_CHECK_EN
      chk("chk_err", int'(chk_err), int'(m_err > 0));
      chk("err_count", int'(err_count), m_err);
`endif
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    cmd_valid = v; cmd_a = a; cmd_b = b; cmd_op = op;
  endtask

  initial begin
    tick(3);
    chk_on = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    tick(1);
    #2 rst_n = 1'b1;
    tick(1);
    chk("post_rst_cmd_ready", int'(cmd_ready), 1);
    chk("post_rst_fifo_count", int'(fifo_count), 0);
    chk("post_rst_alu_a", int'(alu_a), 0);
    chk("post_rst_res_data", int'(res_data), 0);

    chk("model_sub_wrap", int'(alu_fn(cmd_t'({4'd3, 4'd5, 2'd1}))), 8'hFE);

    // Single add: latency check
    res_ready = 1'b1;
    drive(1'b1, 4'd5, 4'd7, 2'd0);
    tick(1);
    drive(1'b0, 4'd0, 4'd0, 2'd0);
    tick(1);
    chk("lat_alu_a", int'(alu_a), 5);
    chk("lat_alu_b", int'(alu_b), 7);
    chk("lat_res_valid_early", int'(res_valid), 0);
    tick(1);
    chk("lat_res_valid", int'(res_valid), 1);
    chk("lat_res_data", int'(res_data), 8'h0C);
    chk("lat_res_op", int'(res_op), 0);
    tick(4);

    // Back-to-back ordering
    got.delete();
    drive(1'b1, 4'd3, 4'd5, 2'd1);   tick(1);
    drive(1'b1, 4'hC, 4'hA, 2'd2);   tick(1);
    drive(1'b1, 4'hC, 4'hA, 2'd3);   tick(1);
    drive(1'b0, 4'd0, 4'd0, 2'd0);
    tick(12);
    chk("b2b_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("b2b_r0", int'(got[0]), int'({2'd1, 8'hFE}));
      chk("b2b_r1", int'(got[1]), int'({2'd2, 8'h08}));
      chk("b2b_r2", int'(got[2]), int'({2'd3, 8'h0E}));
    end

    // Fill with consumer stalled: 5 accepted, 6th refused
    got.delete();
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i + 1), 4'(2 * i), 2'(i % 4));
      tick(1);
    end
    drive(1'b0, 4'd0, 4'd0, 2'd0);
    chk("full_fifo_count", int'(fifo_count), 4);
    chk("full_cmd_ready", int'(cmd_ready), 0);
    res_ready = 1'b1;
    tick(25);
    chk("drain_count", got.size(), 5);
    if (got.size() == 5) begin
      chk("drain_r0", int'(got[0]), int'({2'd0, 8'd1}));
      chk("drain_r4", int'(got[4]), int'({2'd0, 8'd13}));
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom));
      res_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    drive(1'b0, 4'd0, 4'd0, 2'd0);
    res_ready = 1'b1;
    tick(30);
    chk("rand_drained", int'(busy), 0);

    // Reset while in DRIVE with two commands queued
    res_ready = 1'b0;
    drive(1'b1, 4'd9, 4'd2, 2'd1); tick(1);
    drive(1'b0, 4'd0, 4'd0, 2'd0); tick(4);
    chk("hold_res_valid", int'(res_valid), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 4), 4'(i), 2'd0);
      tick(1);
    end
    drive(1'b0, 4'd0, 4'd0, 2'd0);
    res_ready = 1'b1;
    tick(2);
    chk("pre_rst_fifo_count", int'(fifo_count), 2);
    chk("pre_rst_res_valid", int'(res_valid), 0);
    #2 rst_n = 1'b0;
    tick(1);
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_fifo_count", int'(fifo_count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("post_rst_no_result", int'(res_valid), 0);
    end

`ifdef ALU_SEQ_CHECK_EN
    force_zero = 1'b1;
    drive(1'b1, 4'd1, 4'd1, 2'd0); tick(1);
    drive(1'b0, 4'd0, 4'd0, 2'd0); tick(5);
    chk("err_chk_err", int'(chk_err), 1);
    chk("err_err_count", int'(err_count), 1);
    force_zero = 1'b0;
    drive(1'b1, 4'd2, 4'd3, 2'd0); tick(1);
    drive(1'b0, 4'd0, 4'd0, 2'd0); tick(5);
    chk("sticky_chk_err", int'(chk_err), 1);
    chk("sticky_err_count", int'(err_count), 1);
`endif

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator side of the 4-bit ALU operand/result interface. Accepts queued commands (a, b, op) through a valid/ready port and buffers them in a small FIFO. Drives each command onto the ALU operand/op lines, waits a programmable settle time, captures the 8-bit ALU result, and returns it with its op tag through a second valid/ready port. Sits between a host/test controller and the combinational ALU.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
SETTLE, 1, cycles the operands are held on the ALU before the result is sampled; >= 1

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_a  in  4  operand A
cmd_b  in  4  operand B
cmd_op  in  2  0=add, 1=sub, 2=and, 3=or
alu_a  out  4  ALU operand A (registered)
alu_b  out  4  ALU operand B (registered)
alu_op  out  2  ALU op select (registered)
alu_result  in  8  ALU result
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  8  captured ALU result
res_op  out  2  op tag of res_data
busy  out  1  state != IDLE or FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, async): FIFO emptied, state IDLE. alu_a/alu_b/alu_op/res_data/res_op = 0; res_valid = 0; busy = 0; fifo_count = 0. cmd_ready = 1 once out of reset.
- Push: cmd_valid && cmd_ready at an edge writes {a,b,op} to FIFO tail. cmd_ready = (fifo_count < FIFO_DEPTH); no full bypass, so a simultaneous pop does not raise cmd_ready in the same cycle.
- FSM: IDLE, DRIVE, RESP.
- IDLE: if fifo_count > 0, pop head; alu_a/alu_b/alu_op load from head at the same edge; settle counter loads SETTLE-1; go to DRIVE. Otherwise remain in IDLE.
- DRIVE: lasts exactly SETTLE cycles. At the edge ending the last DRIVE cycle: res_data <= alu_result, res_op <= alu_op, res_valid <= 1, go to RESP.
- RESP: hold res_data, res_op and res_valid until res_valid && res_ready. At that edge: res_valid <= 0, go to IDLE.
- alu_* hold their last command between operations and do not return to zero.
- Latency: command accepted at edge E into an empty FIFO with FSM in IDLE -> pop at E+1 -> res_valid high after edge E+1+SETTLE.
- Throughput: at most one op per SETTLE+2 cycles when res_ready is tied high.
- Ordering: results leave in strict command order. Capacity is FIFO_DEPTH queued commands plus one in flight.
- Push during DRIVE or RESP is allowed. Push and pop on the same edge updates fifo_count by net 0.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count range is 0..FIFO_DEPTH.
- Reset mid-operation discards the in-flight command and all queued commands. No result is emitted afterward.

Optional Feature:
Macro ALU_SEQ_CHECK_EN.
- Defined: adds outputs chk_err (1b, sticky) and err_count (8b, saturating at 255), both reset to 0.
- At the sample edge, captured alu_result is compared with an internal reference model computed on 8-bit zero-extended operands:
  add = a+b; sub = (a-b) mod 256; and = a&b; or = a|b, upper nibble 0 for and/or.
- On mismatch: chk_err <= 1 and err_count increments.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Assert rst_n=0 then release -> all outputs 0, cmd_ready=1, busy=0.
2. SETTLE=1, ALU model attached, push a=5 b=7 op=0 at edge E, res_ready=1 -> alu_a=5, alu_b=7 after E+1; res_valid after E+2; res_data=0x0C, res_op=0.
3. Back-to-back pushes: sub 3,5 / and 0xC,0xA / or 0xC,0xA -> results 0xFE, 0x08, 0x0E in order, each op taking 3 cycles.
4. Hold res_ready=0 and push 6 commands (FIFO_DEPTH=4) -> 5 accepted, cmd_ready=0 with fifo_count=4. Release res_ready -> all 5 results returned in order and cmd_ready reasserts after the first pop.
5. Pulse rst_n low while in DRIVE with 2 commands queued -> res_valid=0, fifo_count=0, state IDLE. No result appears in the following 10 cycles.
6. ALU_SEQ_CHECK_EN defined, alu_result forced to 0x00, push add 1+1 -> chk_err=1, err_count=1. A subsequent correct op leaves chk_err=1 and err_count=1.
